// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, grant values and the read data returned on a bus error.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam logic [31:0] BUS_ERR_RDATA = 32'h0;

    function automatic logic is_wait_state(arb_state_e s);
        return (s == ARB_WAIT_I) || (s == ARB_WAIT_D);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory ports around the arbiter.
// master = the arbiter itself, slave = the pipeline stages plus the backing store.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              bus_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, bus_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, bus_err
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational requester pick. MEM_ARBITER_RR_EN selects round-robin on conflicts;
// the default build gives the data requester fixed priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = i_req | d_req;
        // With no requester the grant parks on the last one served; valid gates its use.
        grant = last_grant;
`ifdef MEM_ARBITER_RR_EN
        if (i_req && d_req) begin
            grant = ~last_grant;
        end else if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end
`else
        if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one req/ack memory port with a hung-memory watchdog.
// Arbitration policy comes from arb_pick, controlled by MEM_ARBITER_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic pick_grant;
    logic pick_valid;
    logic wait_fetch;

    arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    assign wait_fetch = (state_q == ARB_WAIT_I);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        // Ready, read data and bus error are single-cycle pulses.
        i_ready_d    = 1'b0;
        i_rdata_d    = '0;
        d_ready_d    = 1'b0;
        d_rdata_d    = '0;
        bus_err_d    = 1'b0;

        if (state_q == ARB_IDLE) begin
            if (pick_valid) begin
                m_req_d      = 1'b1;
                cnt_d        = '0;
                last_grant_d = pick_grant;
                if (pick_grant == GNT_D) begin
                    state_d   = ARB_WAIT_D;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else begin
                    state_d   = ARB_WAIT_I;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                end
            end
        end else if (is_wait_state(state_q)) begin
            if (bus.m_ack) begin
                state_d   = ARB_IDLE;
                m_req_d   = 1'b0;
                m_we_d    = 1'b0;
                m_addr_d  = '0;
                m_wdata_d = '0;
                if (wait_fetch) begin
                    i_ready_d = 1'b1;
                    i_rdata_d = bus.m_rdata;
                end else begin
                    d_ready_d = 1'b1;
                    d_rdata_d = m_we_q ? '0 : bus.m_rdata;
                end
            end else if (cnt_q == CNT_LAST) begin
                // Watchdog: an ack on the limit cycle still wins above, so this is a true hang.
                state_d   = ARB_IDLE;
                m_req_d   = 1'b0;
                m_we_d    = 1'b0;
                m_addr_d  = '0;
                m_wdata_d = '0;
                bus_err_d = 1'b1;
                if (wait_fetch) begin
                    i_ready_d = 1'b1;
                    i_rdata_d = DATA_W'(BUS_ERR_RDATA);
                end else begin
                    d_ready_d = 1'b1;
                    d_rdata_d = DATA_W'(BUS_ERR_RDATA);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            state_d = ARB_IDLE;
            m_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_I;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_ready_q    <= i_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_ready_q    <= d_ready_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] RD_KEY   = 32'h5A5A_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ack   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ RD_KEY;
    endfunction

    task automatic test_reset();
        logic [31:0] outs;
        reset = 1'b1;
        drive_idle();
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        outs = {31'd0, bus.m_req} | {31'd0, bus.m_we} | bus.m_addr | bus.m_wdata |
               {31'd0, bus.i_ready} | {31'd0, bus.d_ready} | bus.i_rdata | bus.d_rdata |
               {31'd0, bus.bus_err};
        total++;
        if (outs !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: or of outputs=%08h required=00000000", outs);
        end

        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        cyc();
        total++;
        if (bus.m_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_wait_entry: m_req=%b required=1", bus.m_req);
        end
        reset = 1'b1; bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
        cyc();
        total++;
        if (bus.m_req !== 1'b0 || bus.d_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait: m_req=%b d_ready=%b required 0 0", bus.m_req, bus.d_ready);
        end
        reset = 1'b0; bus.m_ack = 1'b0; bus.d_req = 1'b0;
        cyc();
        total++;
        if (bus.m_req !== 1'b0 || bus.d_ready !== 1'b0 || bus.d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_late_ready: m_req=%b d_ready=%b d_rdata=%08h required 0 0 0",
                     bus.m_req, bus.d_ready, bus.d_rdata);
        end
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        cyc();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h300 || bus.m_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_regrant: m_req=%b m_addr=%08h m_we=%b required 1 00000300 0",
                     bus.m_req, bus.m_addr, bus.m_we);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_1111;
        cyc();
        bus.m_ack = 1'b0; bus.i_req = 1'b0;
        $display("txn reset-recovery fetch addr=00000300 i_ready=%b rdata=%08h", bus.i_ready, bus.i_rdata);
        cyc();
    endtask

    task automatic test_fetch();
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        cyc();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h40 || bus.m_we !== 1'b0 || bus.m_wdata !== 32'd0) begin
            bad++;
            $display("FAIL fetch_issue: m_req=%b m_addr=%08h m_we=%b m_wdata=%08h required 1 00000040 0 0",
                     bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 32'h2402_000A;
        cyc();
        bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
        total++;
        if (bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h2402_000A || bus.bus_err !== 1'b0 || bus.m_req !== 1'b0) begin
            bad++;
            $display("FAIL fetch_complete: i_ready=%b i_rdata=%08h bus_err=%b m_req=%b required 1 2402000a 0 0",
                     bus.i_ready, bus.i_rdata, bus.bus_err, bus.m_req);
        end
        $display("txn fetch addr=00000040 rdata=%08h", bus.i_rdata);
        bus.i_req = 1'b0;
        cyc();
        total++;
        if (bus.i_ready !== 1'b0 || bus.i_rdata !== 32'd0 || bus.m_req !== 1'b0) begin
            bad++;
            $display("FAIL fetch_after: i_ready=%b i_rdata=%08h m_req=%b required 0 0 0",
                     bus.i_ready, bus.i_rdata, bus.m_req);
        end
    endtask

    task automatic test_write();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1000; bus.d_wdata = 32'hCAFE_BABE;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_wdata !== 32'hCAFE_BABE ||
                bus.m_addr !== 32'h1000 || bus.d_ready !== 1'b0) begin
                bad++;
                $display("FAIL write_hold%0d: m_req=%b m_we=%b m_wdata=%08h m_addr=%08h d_ready=%b required 1 1 cafebabe 00001000 0",
                         k, bus.m_req, bus.m_we, bus.m_wdata, bus.m_addr, bus.d_ready);
            end
            if (k == 4) begin
                bus.m_ack = 1'b1; bus.m_rdata = 32'h7777_7777;
            end
            cyc();
        end
        bus.m_ack = 1'b0;
        total++;
        if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'd0 || bus.bus_err !== 1'b0 || bus.m_req !== 1'b0) begin
            bad++;
            $display("FAIL write_complete: d_ready=%b d_rdata=%08h bus_err=%b m_req=%b required 1 0 0 0",
                     bus.d_ready, bus.d_rdata, bus.bus_err, bus.m_req);
        end
        $display("txn data write addr=00001000 wdata=cafebabe d_ready=%b", bus.d_ready);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        cyc();
        total++;
        if (bus.d_ready !== 1'b0) begin
            bad++;
            $display("FAIL write_single_pulse: d_ready=%b required 0", bus.d_ready);
        end
    endtask

    task automatic test_order();
        string seq;
        string exp_seq;
        int    i_n;
        int    d_n;
        int    mcnt;
`ifdef MEM_ARBITER_RR_EN
        exp_seq = "DIDIDI";
`else
        exp_seq = "DDDIII";
`endif
        seq = "";
        i_n = 0; d_n = 0; mcnt = 0;
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
        for (int c = 0; c < 80 && (i_n < 3 || d_n < 3); c++) begin
            cyc();
            if (bus.i_ready === 1'b1) begin
                total++;
                if (bus.i_rdata !== (bus.i_addr ^ RD_KEY)) begin
                    bad++;
                    $display("FAIL order_i_rdata: i_rdata=%08h required %08h", bus.i_rdata, bus.i_addr ^ RD_KEY);
                end
                $display("txn order fetch addr=%08h rdata=%08h", bus.i_addr, bus.i_rdata);
                seq = {seq, "I"};
                i_n++;
                if (i_n < 3) bus.i_addr = bus.i_addr + 32'd4;
                else bus.i_req = 1'b0;
            end
            if (bus.d_ready === 1'b1) begin
                total++;
                if (bus.d_rdata !== (bus.d_addr ^ RD_KEY)) begin
                    bad++;
                    $display("FAIL order_d_rdata: d_rdata=%08h required %08h", bus.d_rdata, bus.d_addr ^ RD_KEY);
                end
                $display("txn order data addr=%08h rdata=%08h", bus.d_addr, bus.d_rdata);
                seq = {seq, "D"};
                d_n++;
                if (d_n < 3) bus.d_addr = bus.d_addr + 32'd4;
                else bus.d_req = 1'b0;
            end
            if (bus.m_req === 1'b1) begin
                bus.m_ack   = (mcnt == 1);
                bus.m_rdata = bus.m_addr ^ RD_KEY;
                mcnt++;
            end else begin
                mcnt = 0;
                bus.m_ack = 1'b0;
            end
        end
        bus.m_ack = 1'b0;
        total++;
        if (seq != exp_seq) begin
            bad++;
            $display("FAIL order_sequence: got %s required %s", seq, exp_seq);
        end
        cyc();
    endtask

    task automatic test_timeout();
        int nreq;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.m_rdata = 32'hBADB_AD00;
        cyc();
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.m_req !== 1'b1) break;
            nreq++;
            cyc();
        end
        total++;
        if (nreq != MAX_WAIT) begin
            bad++;
            $display("FAIL timeout_mreq_len: m_req cycles=%0d required %0d", nreq, MAX_WAIT);
        end
        total++;
        if (bus.d_ready !== 1'b1 || bus.bus_err !== 1'b1 || bus.d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL timeout_complete: d_ready=%b bus_err=%b d_rdata=%08h required 1 1 0",
                     bus.d_ready, bus.bus_err, bus.d_rdata);
        end
        $display("txn data read addr=00002000 timeout bus_err=%b", bus.bus_err);
        bus.d_req = 1'b0;
        cyc();
        total++;
        if (bus.bus_err !== 1'b0 || bus.d_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: bus_err=%b d_ready=%b required 0 0", bus.bus_err, bus.d_ready);
        end

        bus.d_req = 1'b1; bus.d_addr = 32'h2004;
        cyc();
        for (int k = 1; k <= MAX_WAIT; k++) begin
            if (k == MAX_WAIT) begin
                bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
            end
            cyc();
        end
        bus.m_ack = 1'b0;
        total++;
        if (bus.d_ready !== 1'b1 || bus.bus_err !== 1'b0 || bus.d_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL limit_cycle_ack: d_ready=%b bus_err=%b d_rdata=%08h required 1 0 12345678",
                     bus.d_ready, bus.bus_err, bus.d_rdata);
        end
        $display("txn data read addr=00002004 rdata=%08h bus_err=%b", bus.d_rdata, bus.bus_err);
        bus.d_req = 1'b0;
        cyc();
    endtask

    task automatic test_drop();
        logic extra;
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        cyc();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h80) begin
            bad++;
            $display("FAIL drop_issue: m_req=%b m_addr=%08h required 1 00000080", bus.m_req, bus.m_addr);
        end
        bus.i_req = 1'b0;
        cyc();
        total++;
        if (bus.m_req !== 1'b1) begin
            bad++;
            $display("FAIL drop_no_abort: m_req=%b required 1", bus.m_req);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0BAD_F00D;
        cyc();
        bus.m_ack = 1'b0;
        total++;
        if (bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL drop_ready: i_ready=%b i_rdata=%08h required 1 0badf00d", bus.i_ready, bus.i_rdata);
        end
        $display("txn fetch (dropped req) addr=00000080 rdata=%08h", bus.i_rdata);
        extra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (bus.m_req !== 1'b0 || bus.i_ready !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++;
            $display("FAIL drop_no_reissue: extra activity=%b required 0", extra);
        end
    endtask

    task automatic test_random();
        txn_t        iq[$];
        txn_t        dq[$];
        txn_t        t;
        txn_t        iss_txn;
        txn_t        cur_txn;
        int          i_gap, d_gap, i_done, d_done, mcnt, delay;
        logic        model_last, g, iss_valid, in_wait, busy_now;
        logic        exp_valid, exp_port, exp_err, cur_port;
        logic [31:0] exp_rdata, act_rdata, rv;
        int          cyc_n;
        localparam int N = 20;

        for (int n = 0; n < N; n++) begin
            t.we = 1'b0; t.addr = 32'($urandom_range(0, 15)) * 32'd4; t.wdata = 32'd0;
            iq.push_back(t);
            t.we = 1'($urandom_range(0, 1)); t.addr = 32'($urandom_range(0, 15)) * 32'd4; t.wdata = $urandom;
            dq.push_back(t);
        end
        mem.delete();
        do_reset();
        i_gap = 0; d_gap = 0; i_done = 0; d_done = 0; mcnt = 0; delay = 0;
        model_last = 1'b0; iss_valid = 1'b0; in_wait = 1'b0;
        exp_valid = 1'b0; exp_port = 1'b0; exp_err = 1'b0; exp_rdata = '0; cur_port = 1'b0;
        iss_txn = iq[0]; cur_txn = iq[0];
        cyc_n = 0;

        while ((i_done < N || d_done < N) && cyc_n < 3000) begin
            cyc();
            cyc_n++;
            if (exp_valid) begin
                act_rdata = exp_port ? bus.d_rdata : bus.i_rdata;
                total++;
                if ((exp_port ? (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0)
                              : (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0)) ||
                    bus.bus_err !== exp_err || act_rdata !== exp_rdata || bus.m_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_complete: port=%s i_ready=%b d_ready=%b bus_err=%b rdata=%08h required err=%b rdata=%08h",
                             exp_port ? "D" : "I", bus.i_ready, bus.d_ready, bus.bus_err, act_rdata, exp_err, exp_rdata);
                end
                $display("txn rand %s addr=%08h we=%b rdata=%08h err=%b",
                         exp_port ? "D" : "I", cur_txn.addr, cur_txn.we, act_rdata, bus.bus_err);
                if (exp_port) begin
                    void'(dq.pop_front()); d_done++;
                    d_gap = $urandom_range(0, 2);
                    if (d_gap == 0 && dq.size() > 0) begin
                        bus.d_we = dq[0].we; bus.d_addr = dq[0].addr; bus.d_wdata = dq[0].wdata;
                    end else bus.d_req = 1'b0;
                end else begin
                    void'(iq.pop_front()); i_done++;
                    i_gap = $urandom_range(0, 2);
                    if (i_gap == 0 && iq.size() > 0) bus.i_addr = iq[0].addr;
                    else bus.i_req = 1'b0;
                end
                exp_valid = 1'b0;
            end else begin
                total++;
                if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.bus_err !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_spurious_ready: i_ready=%b d_ready=%b bus_err=%b required 0 0 0",
                             bus.i_ready, bus.d_ready, bus.bus_err);
                end
            end

            if (iss_valid) begin
                total++;
                if (bus.m_req !== 1'b1 || bus.m_we !== iss_txn.we || bus.m_addr !== iss_txn.addr ||
                    bus.m_wdata !== iss_txn.wdata) begin
                    bad++;
                    $display("FAIL rand_issue: m_req=%b m_we=%b m_addr=%08h m_wdata=%08h required 1 %b %08h %08h",
                             bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, iss_txn.we, iss_txn.addr, iss_txn.wdata);
                end
                cur_txn = iss_txn; cur_port = g; mcnt = 0;
                delay = $urandom_range(0, MAX_WAIT + 1);
                in_wait = 1'b1; iss_valid = 1'b0;
            end else if (!in_wait) begin
                total++;
                if (bus.m_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_no_issue: m_req=%b required 0", bus.m_req);
                end
            end
            busy_now = in_wait;

            bus.m_ack = 1'b0;
            bus.m_rdata = $urandom;
            if (in_wait) begin
                mcnt++;
                if (mcnt == delay + 1) begin
                    bus.m_ack = 1'b1;
                    if (cur_txn.we) begin
                        mem[cur_txn.addr] = cur_txn.wdata;
                        exp_rdata = 32'd0;
                    end else begin
                        rv = mem_rd(cur_txn.addr);
                        bus.m_rdata = rv;
                        exp_rdata = rv;
                    end
                    exp_valid = 1'b1; exp_err = 1'b0; exp_port = cur_port; in_wait = 1'b0;
                end else if (mcnt == MAX_WAIT) begin
                    exp_valid = 1'b1; exp_err = 1'b1; exp_rdata = 32'd0; exp_port = cur_port; in_wait = 1'b0;
                end
            end

            if (!bus.i_req && iq.size() > 0) begin
                if (i_gap > 0) i_gap--;
                else begin bus.i_req = 1'b1; bus.i_addr = iq[0].addr; end
            end
            if (!bus.d_req && dq.size() > 0) begin
                if (d_gap > 0) d_gap--;
                else begin
                    bus.d_req = 1'b1; bus.d_we = dq[0].we; bus.d_addr = dq[0].addr; bus.d_wdata = dq[0].wdata;
                end
            end

            // The arbiter is idle whenever no transaction is outstanding this cycle.
            if (!busy_now && (bus.i_req || bus.d_req)) begin
`ifdef MEM_ARBITER_RR_EN
                if (bus.i_req && bus.d_req) g = ~model_last;
                else g = bus.d_req;
`else
                g = bus.d_req;
`endif
                model_last = g;
                iss_valid = 1'b1;
                if (g) iss_txn = dq[0];
                else begin
                    iss_txn.we = 1'b0; iss_txn.addr = iq[0].addr; iss_txn.wdata = 32'd0;
                end
            end
        end
        total++;
        if (i_done != N || d_done != N) begin
            bad++;
            $display("FAIL rand_budget: completed i=%0d d=%0d required %0d each", i_done, d_done, N);
        end
        drive_idle();
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_fetch();
        test_write();
        test_order();
        test_timeout();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
